// File: rtl/midi_pkg.sv
// Shared MIDI definitions: baud rate, status-byte constants, FSM encodings and
// the helper that returns how many data bytes follow a given status byte.
package midi_pkg;

  localparam int MIDI_BAUD = 31250;

  localparam logic [7:0] ST_FLAG_MASK  = 8'h80;
  localparam logic [7:0] ST_CLASS_MASK = 8'hF0;
  localparam logic [7:0] ST_PROG       = 8'hC0;
  localparam logic [7:0] ST_CHPRESS    = 8'hD0;
  localparam logic [7:0] ST_SYSTEM     = 8'hF0;
  localparam logic [7:0] ST_SYSEX      = 8'hF0;
  localparam logic [7:0] ST_MTC        = 8'hF1;
  localparam logic [7:0] ST_SPP        = 8'hF2;
  localparam logic [7:0] ST_SONG       = 8'hF3;
  localparam logic [7:0] ST_TUNE       = 8'hF6;
  localparam logic [7:0] ST_RT_MIN     = 8'hF8;

  typedef enum logic [2:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP,
    U_WAIT_IDLE
  } uart_state_t;

  // P_STAT: status seen, no data yet; P_RUN: running status held, nothing pending.
  typedef enum logic [2:0] {
    P_IDLE,
    P_STAT,
    P_D1,
    P_RUN,
    P_SYSEX
  } parser_state_t;

  function automatic logic [1:0] midi_data_len(input logic [7:0] st);
    logic [1:0] n;
    n = 2'd0;
    if ((st & ST_CLASS_MASK) != ST_SYSTEM) begin
      if ((st & ST_CLASS_MASK) == ST_PROG || (st & ST_CLASS_MASK) == ST_CHPRESS) n = 2'd1;
      else n = 2'd2;
    end else if (st == ST_MTC || st == ST_SONG) begin
      n = 2'd1;
    end else if (st == ST_SPP) begin
      n = 2'd2;
    end
    return n;
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// Oversampling 8N1 receiver: input synchroniser, 16x sample timing and the
// framing FSM; each frame yields either one byte strobe or one framing-error strobe.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_DIV_16X = 200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int               DIV_W      = $clog2(CLK_DIV_16X + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV_16X - 1);
  localparam logic [3:0]       MID_SAMPLE = 4'd7;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DIV_W-1:0]       div_q;
  logic [3:0]             s_q;
  logic [2:0]             bit_q;
  logic [7:0]             shift_q;
  uart_state_t            state_q, state_d;
  logic                   rx;
  logic                   tick;
  logic                   sample;

  assign rx     = sync_q[SYNC_STAGES-1];
  assign tick   = (div_q == DIV_LAST);
  assign sample = tick && (s_q == MID_SAMPLE);
  assign byte_o = shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      div_q   <= '0;
      s_q     <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      div_q  <= tick ? '0 : div_q + DIV_W'(1);
      // The falling start edge realigns the sample counter; it then free-runs so
      // every bit is sampled 16 ticks after the previous one.
      if (state_q == U_IDLE && !rx) s_q <= '0;
      else if (tick)                s_q <= s_q + 4'd1;
      if (state_q == U_IDLE)               bit_q <= '0;
      else if (state_q == U_DATA && sample) bit_q <= bit_q + 3'd1;
      if (state_q == U_DATA && sample) shift_q <= {rx, shift_q[7:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= U_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      U_IDLE:      if (!rx) state_d = U_START;
      U_START:     if (sample) state_d = rx ? U_IDLE : U_DATA;
      U_DATA:      if (sample && bit_q == 3'd7) state_d = U_STOP;
      U_STOP:      if (sample) state_d = rx ? U_IDLE : U_WAIT_IDLE;
      U_WAIT_IDLE: if (rx) state_d = U_IDLE;
      default:     state_d = U_IDLE;
    endcase
  end

  always_comb begin
    byte_valid_o = (state_q == U_STOP) && sample && rx;
    frame_err_o  = (state_q == U_STOP) && sample && !rx;
    busy_o       = (state_q == U_START) || (state_q == U_DATA) || (state_q == U_STOP);
  end

endmodule

// File: rtl/midi_rx_decoder.sv
// MIDI receive decoder: UART front end plus message framer with running status,
// real-time passthrough and SysEx discard.
module midi_rx_decoder
  import midi_pkg::*;
#(
  parameter int CLK_DIV_16X = 100_000_000 / (MIDI_BAUD * 16),
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx,
  output logic [7:0] status,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [1:0] bytes_cnt,
  output logic       msg_valid,
  output logic [7:0] rt_byte,
  output logic       rt_valid,
  output logic       frame_err,
  output logic       busy
);

  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  midi_uart_rx #(
    .CLK_DIV_16X(CLK_DIV_16X),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_uart (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (midi_rx),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_byte_valid),
    .frame_err_o (rx_frame_err),
    .busy_o      (rx_busy)
  );

  parser_state_t pst_q, pst_d;
  logic [7:0] rs_q, rs_d;
  logic [7:0] d1_q, d1_d;
  logic [7:0] status_q, data1_q, data2_q, rt_byte_q;
  logic [1:0] cnt_q;
  logic       msg_valid_q, rt_valid_q, frame_err_q;

  logic       is_rt, is_data, is_chan_st, is_common, rs_chan, accepting, data_done;
  logic [1:0] need_rs;
  logic       emit;
  logic [7:0] em_st, em_d1, em_d2;
  logic [1:0] em_cnt;

  always_comb begin
    is_rt      = (rx_byte >= ST_RT_MIN);
    is_data    = ((rx_byte & ST_FLAG_MASK) == 8'h00);
    is_chan_st = !is_data && (rx_byte < ST_SYSTEM);
    is_common  = (rx_byte == ST_MTC) || (rx_byte == ST_SPP) || (rx_byte == ST_SONG);
    rs_chan    = (rs_q < ST_SYSTEM);
    need_rs    = midi_data_len(rs_q);
    accepting  = (pst_q == P_STAT) || (pst_q == P_RUN) || (pst_q == P_D1);
    data_done  = (pst_q == P_D1) || (need_rs == 2'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pst_q <= P_IDLE;
    else     pst_q <= pst_d;
  end

  // Status bytes are handled the same from every state, which also ends SysEx.
  always_comb begin
    pst_d = pst_q;
    if (rx_byte_valid && !is_rt) begin
      if (!is_data) begin
        if (rx_byte == ST_SYSEX)           pst_d = P_SYSEX;
        else if (is_chan_st || is_common) pst_d = P_STAT;
        else                              pst_d = P_IDLE;
      end else if (accepting) begin
        if (data_done) pst_d = rs_chan ? P_RUN : P_IDLE;
        else           pst_d = P_D1;
      end
    end
  end

  always_comb begin
    emit   = 1'b0;
    em_st  = rs_q;
    em_d1  = 8'h00;
    em_d2  = 8'h00;
    em_cnt = 2'd1 + need_rs;
    rs_d   = rs_q;
    d1_d   = d1_q;
    if (rx_byte_valid && !is_rt) begin
      if (!is_data) begin
        rs_d = (is_chan_st || is_common) ? rx_byte : 8'h00;
        if (rx_byte == ST_TUNE) begin
          emit   = 1'b1;
          em_st  = rx_byte;
          em_cnt = 2'd1;
        end
      end else if (accepting) begin
        if (data_done) begin
          emit  = 1'b1;
          em_d1 = (pst_q == P_D1) ? d1_q : rx_byte;
          em_d2 = (pst_q == P_D1) ? rx_byte : 8'h00;
          if (!rs_chan) rs_d = 8'h00;
        end else begin
          d1_d = rx_byte;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q        <= '0;
      d1_q        <= '0;
      status_q    <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      cnt_q       <= '0;
      msg_valid_q <= 1'b0;
      rt_byte_q   <= '0;
      rt_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rs_q        <= rs_d;
      d1_q        <= d1_d;
      msg_valid_q <= emit;
      rt_valid_q  <= rx_byte_valid && is_rt;
      frame_err_q <= rx_frame_err;
      if (emit) begin
        status_q <= em_st;
        data1_q  <= em_d1;
        data2_q  <= em_d2;
        cnt_q    <= em_cnt;
      end
      if (rx_byte_valid && is_rt) rt_byte_q <= rx_byte;
    end
  end

  assign status    = status_q;
  assign data1     = data1_q;
  assign data2     = data2_q;
  assign bytes_cnt = cnt_q;
  assign msg_valid = msg_valid_q;
  assign rt_byte   = rt_byte_q;
  assign rt_valid  = rt_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = rx_busy || (pst_q == P_STAT) || (pst_q == P_D1);

endmodule

// File: tb/tb_midi_rx_decoder.sv
// Bench for midi_rx_decoder: serial byte driver, output monitor, vector table,
// corner-case sequences and a randomized stream checked against a message model.
module tb_midi_rx_decoder;

  localparam int DIV = 2;
  localparam int BIT = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       midi_rx = 1'b1;
  logic [7:0] status, data1, data2, rt_byte;
  logic [1:0] bytes_cnt;
  logic       msg_valid, rt_valid, frame_err, busy;

  midi_rx_decoder #(.CLK_DIV_16X(DIV), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .midi_rx  (midi_rx),
    .status   (status),
    .data1    (data1),
    .data2    (data2),
    .bytes_cnt(bytes_cnt),
    .msg_valid(msg_valid),
    .rt_byte  (rt_byte),
    .rt_valid (rt_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] cnt;
  } msg_t;

  typedef struct {
    logic [63:0] seq;
    int          nb;
    int          nmsg;
    msg_t        last;
    int          nrt;
    logic [7:0]  rtb;
  } vec_t;

  vec_t       vecs[$];
  msg_t       got_msg[$];
  msg_t       exp_msg[$];
  logic [7:0] got_rt[$];
  logic [7:0] exp_rt[$];
  logic [7:0] rnd[$];
  int         fe_cnt = 0;
  int         ovl_cnt = 0;
  int         total = 0;
  int         bad = 0;

  always @(negedge clk) begin
    if (msg_valid) got_msg.push_back({status, data1, data2, bytes_cnt});
    if (rt_valid) got_rt.push_back(rt_byte);
    if (frame_err) fe_cnt++;
    if ((msg_valid && rt_valid) || ((msg_valid || rt_valid) && frame_err)) ovl_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopv);
    midi_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    midi_rx = stopv;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    midi_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  function automatic void add_vec(input logic [63:0] seq, input int nb, input int nmsg,
                                  input msg_t last, input int nrt, input logic [7:0] rtb);
    vec_t v;
    v.seq  = seq;
    v.nb   = nb;
    v.nmsg = nmsg;
    v.last = last;
    v.nrt  = nrt;
    v.rtb  = rtb;
    vecs.push_back(v);
  endfunction

  // Message-level model: running status is a remembered status (or none); SysEx and
  // undefined/ending system bytes simply leave no running status, so data is dropped.
  task automatic ref_model();
    int         rs;
    int         got;
    int         need;
    logic [7:0] b;
    logic [7:0] d[2];
    rs  = -1;
    got = 0;
    foreach (rnd[i]) begin
      b = rnd[i];
      if (b >= 8'hF8) begin
        exp_rt.push_back(b);
      end else if (b >= 8'h80) begin
        got = 0;
        if (b < 8'hF0 || b == 8'hF1 || b == 8'hF2 || b == 8'hF3) rs = int'(b);
        else rs = -1;
        if (b == 8'hF6) exp_msg.push_back({8'hF6, 8'h00, 8'h00, 2'd1});
      end else if (rs >= 0) begin
        need = ((rs / 16) == 12 || (rs / 16) == 13 || rs == 'hF1 || rs == 'hF3) ? 1 : 2;
        d[got] = b;
        got++;
        if (got == need) begin
          exp_msg.push_back({8'(rs), d[0], (need == 2) ? d[1] : 8'h00, 2'(need + 1)});
          got = 0;
          if (rs >= 'hF0) rs = -1;
        end
      end
    end
  endtask

  initial begin
    int         mb, rb, fb, r, sc;
    msg_t       m;
    logic [7:0] lb;

    repeat (3) @(negedge clk);
    chk("reset_data", {status, data1, data2, rt_byte}, 32'h0);
    chk("reset_ctrl", 32'({bytes_cnt, msg_valid, rt_valid, frame_err, busy}), 32'h0);

    add_vec(64'h903C64_0000000000, 3, 1, {8'h90, 8'h3C, 8'h64, 2'd3}, 0, 8'h00);
    add_vec(64'h903C643E50_000000, 5, 2, {8'h90, 8'h3E, 8'h50, 2'd3}, 0, 8'h00);
    add_vec(64'hC042_000000000000, 2, 1, {8'hC0, 8'h42, 8'h00, 2'd2}, 0, 8'h00);
    add_vec(64'hB02EF87F_00000000, 4, 1, {8'hB0, 8'h2E, 8'h7F, 2'd3}, 1, 8'hF8);
    add_vec(64'hF00102F7803C00_00, 7, 1, {8'h80, 8'h3C, 8'h00, 2'd3}, 0, 8'h00);
    add_vec(64'h3C40_000000000000, 2, 0, '0, 0, 8'h00);
    add_vec(64'hF6_00000000000000, 1, 1, {8'hF6, 8'h00, 8'h00, 2'd1}, 0, 8'h00);
    add_vec(64'hF21020_0000000000, 3, 1, {8'hF2, 8'h10, 8'h20, 2'd3}, 0, 8'h00);
    add_vec(64'hF210F305_00000000, 4, 1, {8'hF3, 8'h05, 8'h00, 2'd2}, 0, 8'h00);
    add_vec(64'hD01020_0000000000, 3, 2, {8'hD0, 8'h20, 8'h00, 2'd2}, 0, 8'h00);
    add_vec(64'hF30506_0000000000, 3, 1, {8'hF3, 8'h05, 8'h00, 2'd2}, 0, 8'h00);
    add_vec(64'h903CFE64_00000000, 4, 1, {8'h90, 8'h3C, 8'h64, 2'd3}, 1, 8'hFE);
    add_vec(64'hF07F901020_000000, 5, 1, {8'h90, 8'h10, 8'h20, 2'd3}, 0, 8'h00);
    add_vec(64'hE0007F_0000000000, 3, 1, {8'hE0, 8'h00, 8'h7F, 2'd3}, 0, 8'h00);

    foreach (vecs[k]) begin
      do_reset();
      mb = got_msg.size();
      rb = got_rt.size();
      for (int i = 0; i < vecs[k].nb; i++) send_byte(vecs[k].seq[63 - 8*i -: 8]);
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_nmsg", k), 32'(got_msg.size() - mb), 32'(vecs[k].nmsg));
      if (vecs[k].nmsg > 0) begin
        m = '0;
        if (got_msg.size() > mb) m = got_msg[got_msg.size() - 1];
        chk($sformatf("v%0d_msg", k), 32'(m), 32'(vecs[k].last));
      end
      chk($sformatf("v%0d_nrt", k), 32'(got_rt.size() - rb), 32'(vecs[k].nrt));
      if (vecs[k].nrt > 0) begin
        lb = 8'h00;
        if (got_rt.size() > rb) lb = got_rt[got_rt.size() - 1];
        chk($sformatf("v%0d_rt", k), 32'(lb), 32'(vecs[k].rtb));
      end
    end

    // busy follows partial assembly
    do_reset();
    send_byte(8'h90);
    chk("busy_after_status", 32'(busy), 32'd1);
    send_byte(8'h3C);
    chk("busy_after_data1", 32'(busy), 32'd1);
    send_byte(8'h64);
    chk("busy_after_msg", 32'(busy), 32'd0);

    // reset in the middle of a byte
    midi_rx = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    chk("busy_mid_byte", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_data", {status, data1, data2, rt_byte}, 32'h0);
    chk("rst_mid_ctrl", 32'({bytes_cnt, msg_valid, rt_valid, frame_err, busy}), 32'h0);
    midi_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (BIT) @(negedge clk);
    mb = got_msg.size();
    send_byte(8'h3C);
    send_byte(8'h40);
    chk("post_rst_no_rs", 32'(got_msg.size() - mb), 32'd0);
    send_byte(8'h90);
    send_byte(8'h3C);
    send_byte(8'h64);
    chk("post_rst_nmsg", 32'(got_msg.size() - mb), 32'd1);
    m = '0;
    if (got_msg.size() > mb) m = got_msg[got_msg.size() - 1];
    chk("post_rst_msg", 32'(m), 32'({8'h90, 8'h3C, 8'h64, 2'd3}));

    // stop bit low, then line held low
    rb = got_rt.size();
    fb = fe_cnt;
    send_frame(8'hF8, 1'b0);
    repeat (3 * BIT) @(negedge clk);
    chk("ferr_pulses", 32'(fe_cnt - fb), 32'd1);
    chk("ferr_no_byte", 32'(got_rt.size() - rb), 32'd0);
    midi_rx = 1'b1;
    repeat (BIT) @(negedge clk);
    send_byte(8'hF8);
    chk("ferr_recover_rt", 32'(got_rt.size() - rb), 32'd1);
    chk("ferr_no_more", 32'(fe_cnt - fb), 32'd1);

    // short low glitch
    mb = got_msg.size();
    rb = got_rt.size();
    fb = fe_cnt;
    midi_rx = 1'b0;
    repeat (5 * DIV) @(negedge clk);
    midi_rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("glitch_no_event", 32'((got_msg.size() - mb) + (got_rt.size() - rb) + (fe_cnt - fb)), 32'd0);
    send_byte(8'hFA);
    lb = 8'h00;
    if (got_rt.size() > rb) lb = got_rt[got_rt.size() - 1];
    chk("glitch_then_rt", 32'(lb), 32'hFA);

    // randomized stream
    do_reset();
    for (int i = 0; i < 45; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50) rnd.push_back(8'($urandom_range(0, 127)));
      else if (r < 72) rnd.push_back(8'($urandom_range(128, 239)));
      else if (r < 82) begin
        sc = int'($urandom_range(0, 3));
        rnd.push_back((sc == 0) ? 8'hF1 : (sc == 1) ? 8'hF2 : (sc == 2) ? 8'hF3 : 8'hF6);
      end else if (r < 90) rnd.push_back(8'($urandom_range(248, 255)));
      else begin
        rnd.push_back(8'hF0);
        rnd.push_back(8'($urandom_range(0, 127)));
        rnd.push_back(8'hF7);
      end
    end
    ref_model();
    mb = got_msg.size();
    rb = got_rt.size();
    fb = fe_cnt;
    foreach (rnd[i]) send_byte(rnd[i]);
    repeat (4) @(negedge clk);
    chk("rnd_nmsg", 32'(got_msg.size() - mb), 32'(exp_msg.size()));
    foreach (exp_msg[i]) begin
      if (mb + i < got_msg.size()) chk($sformatf("rnd_msg%0d", i), 32'(got_msg[mb + i]), 32'(exp_msg[i]));
    end
    chk("rnd_nrt", 32'(got_rt.size() - rb), 32'(exp_rt.size()));
    foreach (exp_rt[i]) begin
      if (rb + i < got_rt.size()) chk($sformatf("rnd_rt%0d", i), 32'(got_rt[rb + i]), 32'(exp_rt[i]));
    end
    chk("rnd_no_ferr", 32'(fe_cnt - fb), 32'd0);
    chk("pulse_overlap", 32'(ovl_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
